// File: rtl/sound_player.sv
// sound_player: walks the recorder read port, holds each sample
// and renders it as a registered 1-bit PWM stream.
`timescale 1ns/1ps
module sound_player #(
  parameter int unsigned SAMPLE_INTERVAL_CLK = 3000,
  parameter int unsigned READ_LATENCY        = 2,
  parameter logic [9:0]  MIDSCALE            = 10'd512
) (
  input  logic        clk,
  input  logic        reset_n_clk,
  input  logic        play_n,
  input  logic        record_n,
  input  logic [15:0] write_pointer,
  input  logic [9:0]  read_data,
  output logic [15:0] read_pointer,
  output logic        busy,
  output logic        done,
  output logic [9:0]  sample_out,
  output logic        pwm_out
);

  typedef enum logic {
    IDLE,
    PLAY
  } state_t;

  localparam logic [31:0] LAST_CNT = 32'(SAMPLE_INTERVAL_CLK - 1);
  localparam logic [31:0] LAT_CNT  = 32'(READ_LATENCY);

  state_t      state_q, state_d;
  logic        play_n_d_q;
  logic [15:0] read_pointer_q, read_pointer_d;
  logic [31:0] interval_cnt_q, interval_cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [9:0]  sample_q, sample_d;
  logic [9:0]  pwm_cnt_q, pwm_cnt_d;
  logic        pwm_out_q, pwm_out_d;

  logic start;
  logic abort;
  logic last;

  assign start = play_n_d_q & ~play_n;
  assign abort = play_n | ~record_n;
  assign last  = ({1'b0, read_pointer_q} + 17'd1)
               >= {1'b0, write_pointer};

  // Playback FSM: start, sample latch, boundary advance, abort.
  always_comb begin
    state_d        = state_q;
    read_pointer_d = read_pointer_q;
    interval_cnt_d = interval_cnt_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    sample_d       = sample_q;
    unique case (state_q)
      IDLE: begin
        if (start && record_n && write_pointer != 16'd0) begin
          state_d        = PLAY;
          read_pointer_d = 16'd0;
          interval_cnt_d = 32'd0;
          busy_d         = 1'b1;
        end
      end
      PLAY: begin
        if (abort) begin
          state_d        = IDLE;
          busy_d         = 1'b0;
          read_pointer_d = 16'd0;
          interval_cnt_d = 32'd0;
          sample_d       = MIDSCALE;
        end else begin
          if (interval_cnt_q == LAT_CNT) begin
            sample_d = {~read_data[9], read_data[8:0]};
          end
          if (interval_cnt_q == LAST_CNT) begin
            if (last) begin
              state_d        = IDLE;
              busy_d         = 1'b0;
              done_d         = 1'b1;
              read_pointer_d = 16'd0;
              interval_cnt_d = 32'd0;
              sample_d       = MIDSCALE;
            end else begin
              read_pointer_d = read_pointer_q + 16'd1;
              interval_cnt_d = 32'd0;
            end
          end else begin
            interval_cnt_d = interval_cnt_q + 32'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Free-running PWM carrier compared against the held sample.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 10'd1;
    pwm_out_d = (pwm_cnt_q < sample_q);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n_clk) begin
    if (!reset_n_clk) begin
      state_q        <= IDLE;
      play_n_d_q     <= 1'b1;
      read_pointer_q <= 16'd0;
      interval_cnt_q <= 32'd0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      sample_q       <= MIDSCALE;
      pwm_cnt_q      <= 10'd0;
      pwm_out_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      play_n_d_q     <= play_n;
      read_pointer_q <= read_pointer_d;
      interval_cnt_q <= interval_cnt_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      sample_q       <= sample_d;
      pwm_cnt_q      <= pwm_cnt_d;
      pwm_out_q      <= pwm_out_d;
    end
  end

  assign read_pointer = read_pointer_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign sample_out   = sample_q;
  assign pwm_out      = pwm_out_q;

endmodule
